// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmitter and its companion serial receivers.
// Holds the FSM state type and the counter/index width helper.
package piso_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to count 0..n-1, never less than one so a degenerate counter still has a port.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        if (n <= 32'd1) begin
            w = 32'd1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_rshift_tx_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled and flags the last cycle of each period.
// Shared between the transmitter and the matching serial receiver.
module bit_timer
    import piso_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned   CW       = cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

    logic [CW-1:0] cnt_r;
    logic          wrap_s;

    // Period boundary decode; tick only counts while the timer is running.
    always_comb begin
        wrap_s = (cnt_r == CNT_LAST);
        tick   = enable && wrap_s;
    end

    // Period counter: clear wins, otherwise count and wrap at the end of the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clear) begin
            cnt_r <= CNT_ZERO;
        end else if (enable) begin
            if (wrap_s) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/piso_rshift_tx.sv
// Parallel-in serial-out transmitter: shifts a WIDTH-bit word out LSB first,
// BIT_CYCLES clocks per bit, with frame start/last markers and back-to-back loading.
module piso_rshift_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int unsigned   IW       = cnt_width(WIDTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 32'd1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(32'd0);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [IW-1:0]    idx_r;
    logic             in_shift_s;
    logic             frame_end_s;
    logic             accept_s;
    logic             tick_s;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept_s),
        .enable (in_shift_s),
        .tick   (tick_s)
    );

    // Handshake and next-state: ready in IDLE or on the final cycle of a frame so frames can abut.
    always_comb begin
        in_shift_s  = (state_r == ST_SHIFT);
        frame_end_s = in_shift_s && (idx_r == IDX_LAST) && tick_s;
        load_ready  = (state_r == ST_IDLE) || frame_end_s;
        accept_s    = load_valid && load_ready;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (frame_end_s && !accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shift register and bit index: load on accept, otherwise advance one bit per period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= '0;
            idx_r   <= IDX_ZERO;
        end else if (accept_s) begin
            shreg_r <= load_data;
            idx_r   <= IDX_ZERO;
        end else if (in_shift_s && tick_s) begin
            shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            if (idx_r == IDX_LAST) begin
                idx_r <= IDX_ZERO;
            end else begin
                idx_r <= idx_r + IDX_ONE;
            end
        end else begin
            shreg_r <= shreg_r;
            idx_r   <= idx_r;
        end
    end

    // Serial outputs are a pure decode of registered state, forced quiet outside a frame.
    always_comb begin
        sout        = 1'b0;
        sout_valid  = 1'b0;
        frame_start = 1'b0;
        frame_last  = 1'b0;
        if (in_shift_s) begin
            sout        = shreg_r[0];
            sout_valid  = 1'b1;
            frame_start = (idx_r == IDX_ZERO);
            frame_last  = (idx_r == IDX_LAST);
        end else begin
            sout        = 1'b0;
            sout_valid  = 1'b0;
            frame_start = 1'b0;
            frame_last  = 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_rshift_tx.sv
// Self-checking bench for piso_rshift_tx: table-driven vectors, hand sequences for
// reset / slow bit period / receiver loopback, and randomized traffic against a frame model.
module tb_piso_rshift_tx;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         lv1, lr1, so1, sv1, fs1, fl1;
    logic [W-1:0] ld1;
    logic         lv3, lr3, so3, sv3, fs3, fl3;
    logic [W-1:0] ld3;
    logic [W-1:0] rx;

    int checks;
    int errors;

    piso_rshift_tx #(.WIDTH(W), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
        .sout(so1), .sout_valid(sv1), .frame_start(fs1), .frame_last(fl1)
    );

    piso_rshift_tx #(.WIDTH(W), .BIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv3), .load_data(ld3), .load_ready(lr3),
        .sout(so3), .sout_valid(sv3), .frame_start(fs3), .frame_last(fl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit SISO right-shift receiver fed from the fast transmitter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx <= '0;
        else if (sv1) rx <= {so1, rx[W-1:1]};
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct packed {
        logic         lv;
        logic [W-1:0] ld;
        logic         s;
        logic         v;
        logic         fs;
        logic         fl;
        logic         rdy;
    } vec_t;

    vec_t tbl[24];

    // Frame model state per DUT (index 0: BIT_CYCLES=1, index 1: BIT_CYCLES=3).
    int           rem [2];
    int           pos [2];
    logic [W-1:0] word[2];
    int           bc  [2];

    initial begin
        logic [W-1:0] w;
        logic         e_s, e_v, e_fs, e_fl, e_rdy, lv_r;
        logic [W-1:0] ld_r;
        int           b;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        lv1 = 1'b1; ld1 = 4'b1111;
        lv3 = 1'b0; ld3 = 4'b0000;

        // Reset held: everything quiet, ready asserted.
        repeat (2) @(negedge clk);
        chk("rst_sout", so1, 1'b0);
        chk("rst_valid", sv1, 1'b0);
        chk("rst_fs", fs1, 1'b0);
        chk("rst_fl", fl1, 1'b0);
        chk("rst_ready", lr1, 1'b1);
        chk("rst_ready3", lr3, 1'b1);
        chk("rst_valid3", sv3, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_bit_sout", so1, 1'b1);
        chk("first_bit_valid", sv1, 1'b1);
        chk("first_bit_fs", fs1, 1'b1);
        lv1 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sout", so1, 1'b0);
        chk("midrst_valid", sv1, 1'b0);
        chk("midrst_ready", lr1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_resume_valid", sv1, 1'b0);

        // Table: single frame, back-to-back, backpressure.
        tbl[0]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 4'b1100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[23] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_sout", i), so1, tbl[i].s);
            chk($sformatf("tbl%0d_valid", i), sv1, tbl[i].v);
            chk($sformatf("tbl%0d_fs", i), fs1, tbl[i].fs);
            chk($sformatf("tbl%0d_fl", i), fl1, tbl[i].fl);
            chk($sformatf("tbl%0d_ready", i), lr1, tbl[i].rdy);
            lv1 = tbl[i].lv;
            ld1 = tbl[i].ld;
        end

        // Slow bit period: 4'b1010 with three cycles per bit.
        w = 4'b1010;
        @(negedge clk);
        lv3 = 1'b1; ld3 = w;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            lv3 = 1'b0;
            b = (c - 1) / 3;
            chk($sformatf("bc3_c%0d_sout", c), so3, w[b]);
            chk($sformatf("bc3_c%0d_valid", c), sv3, 1'b1);
            chk($sformatf("bc3_c%0d_fs", c), fs3, (c <= 3) ? 1'b1 : 1'b0);
            chk($sformatf("bc3_c%0d_ready", c), lr3, (c == 12) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        chk("bc3_idle_valid", sv3, 1'b0);
        chk("bc3_idle_sout", so3, 1'b0);

        // Loopback into the SISO receiver.
        lv1 = 1'b1; ld1 = 4'b1011;
        @(negedge clk);
        lv1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("siso_rx", rx, 4'b1011);

        // Randomized traffic against the frame model.
        bc[0] = 1; bc[1] = 3;
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; pos[d] = 0; word[d] = '0;
        end
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                e_v   = (rem[d] > 0);
                b     = pos[d] / bc[d];
                e_s   = e_v ? word[d][b] : 1'b0;
                e_fs  = e_v && (b == 0);
                e_fl  = e_v && (b == W - 1);
                e_rdy = (rem[d] <= 1);
                lv_r  = ($urandom_range(0, 9) < 4);
                ld_r  = W'($urandom);
                if (d == 0) begin
                    chk("rnd1_sout", so1, e_s);
                    chk("rnd1_valid", sv1, e_v);
                    chk("rnd1_fs", fs1, e_fs);
                    chk("rnd1_fl", fl1, e_fl);
                    chk("rnd1_ready", lr1, e_rdy);
                    lv1 = lv_r; ld1 = ld_r;
                end else begin
                    chk("rnd3_sout", so3, e_s);
                    chk("rnd3_valid", sv3, e_v);
                    chk("rnd3_fs", fs3, e_fs);
                    chk("rnd3_fl", fl3, e_fl);
                    chk("rnd3_ready", lr3, e_rdy);
                    lv3 = lv_r; ld3 = ld_r;
                end
                if (lv_r && e_rdy) begin
                    word[d] = ld_r;
                    pos[d]  = 0;
                    rem[d]  = W * bc[d];
                end else if (rem[d] > 0) begin
                    rem[d]--;
                    pos[d]++;
                end
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_rshift_tx.md
# piso_rshift_tx

Parallel-in, serial-out right-shift transmitter that produces the bit stream consumed by the team's serial-in shift-register receivers. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, one bit per bit period. It also marks the first and last bit of each frame. It sits between a parallel data source and any SISO/SIPO receiver on the same serial line.

## Interface
- WIDTH, 4, word length in bits; must be ≥ 2.
- BIT_CYCLES, 1, clock cycles each bit is held on `sout`; must be ≥ 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  the source presents a word on `load_data`.
- load_data  in  WIDTH  word to transmit; bit 0 is transmitted first.
- load_ready  out  1  the transmitter can accept a word this cycle.
- sout  out  1  serial data; 0 when not transmitting.
- sout_valid  out  1  `sout` carries a frame bit.
- frame_start  out  1  high during the bit period of bit 0.
- frame_last  out  1  high during the bit period of bit WIDTH-1.

## Operation
- States: IDLE and SHIFT.
- **Accept.** A word is accepted on a rising edge where `load_valid && load_ready`.
  - The edge loads the shift register with `load_data`, clears the bit index and the period counter, and enters SHIFT.
- **Transmit.** In SHIFT:
  - `sout` = `shreg[0]` and `sout_valid` = 1.
  - The period counter counts 0..BIT_CYCLES-1.
  - When the counter reaches BIT_CYCLES-1, the register shifts right (zero fill into the MSB), the bit index increments, and the counter wraps to 0.
- **Ready.** `load_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only when bit index = WIDTH-1 and counter = BIT_CYCLES-1, i.e. the final cycle of the frame.
  - 0 at all other times.
- **End of frame.** At the end of the last bit period:
  - If a word is accepted on that edge, the new frame starts with no gap (back-to-back).
  - Otherwise the block returns to IDLE.
- **Framing flags.** `frame_start` = SHIFT && index = 0. `frame_last` = SHIFT && index = WIDTH-1.
- **IDLE outputs.** `sout` = 0, `sout_valid` = 0, `frame_start` = 0, `frame_last` = 0.
- **Data stability.** `load_data` is ignored whenever `load_ready` = 0, and a word that is not accepted has no effect. Changing `load_data` mid-frame does not disturb the frame in progress.
- **Reset mid-frame.** Asserting reset aborts the frame immediately and asynchronously. No partial frame resumes after reset.

## Timing
- **Reset values:** state = IDLE, shift register = 0, index = 0, counter = 0, `sout` = 0, `sout_valid` = 0, `frame_start` = 0, `frame_last` = 0, `load_ready` = 1.
- **Latency:** bit 0 appears on `sout` in the cycle right after the accept edge.
- **Frame length:** WIDTH × BIT_CYCLES cycles. Back-to-back throughput is 1 word per WIDTH × BIT_CYCLES cycles.
- **Reset release:** the first accept can occur on the first rising edge after `rst_n` deasserts.
- **Widths:** index width is $clog2(WIDTH); counter width is $clog2(BIT_CYCLES), with a minimum of 1.

## Structure
- **Shared package `piso_pkg`:**
  - State enum {ST_IDLE, ST_SHIFT}.
  - Width-helper function for the index and counter widths.
- **Sub-module `bit_timer`:** a parameterised BIT_CYCLES period counter with `clear` input and `tick` output. It is reused by the future receiver.
- **Top level:** the state register, shift register, index, and handshake logic.

## Test plan
1. **Reset mid-frame:** hold `rst_n` = 0, then release, load 4'b1111 and pull `rst_n` low at the second bit. Required:
   - All outputs read 0 and `load_ready` = 1 while reset is held.
   - After the mid-frame reset, `sout` and `sout_valid` drop at once and `load_ready` = 1.
2. **Single frame, WIDTH = 4, BIT_CYCLES = 1:** load 4'b0110. Required:
   - `sout` = 0,1,1,0 on 4 consecutive cycles with `sout_valid` = 1.
   - `frame_start` on cycle 1 and `frame_last` on cycle 4.
   - Then IDLE with `sout` = 0.
3. **Back-to-back:** keep `load_valid` high with 4'b0110 then 4'b1001. Required:
   - `sout` = 0,1,1,0,1,0,0,1 with no idle cycle.
   - `load_ready` high only on cycles 4 and 8.
4. **BIT_CYCLES = 3:** load 4'b1010. Required:
   - `sout` = 0,0,0,1,1,1,0,0,0,1,1,1.
   - `frame_start` high for 3 cycles.
   - `load_ready` high only on cycle 12.
5. **Backpressure:** change `load_data` and pulse `load_valid` mid-frame. Required:
   - The in-flight frame is unchanged.
   - The pulse is not accepted.
   - The held word is accepted only on the final frame cycle.
6. **Cross-check with a receiver:** drive `sout` into a 4-bit SISO right-shift register. Required: after 4 shift cycles its contents equal the loaded word.
